piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter for the serial channel. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. Words are shifted out MSB first, one bit per clock, with a per-word start marker and a completion pulse. Back-to-back words stream with no idle bit between them, so a serial-in/parallel-out receiver on the far end can reassemble them.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_serializer.sv | 80 ++++++++
 tb/tb_piso_serializer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serial transmitter: FSM state type,
// default word width and counter width helper.
package piso_pkg;

  localparam int unsigned PISO_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one-word holding buffer feeding an
// MSB-first shifter, with start-of-word marker and completion pulse.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] Din,
  output logic             Sout,
  output logic             frame,
  output logic             sof,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  // Accept (needs hold empty) and transfer (needs hold full) are mutually
  // exclusive, so the hold_full updates below can never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      sreg      <= '0;
      cnt       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_valid && !hold_full) begin
        hold      <= Din;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_full) begin
            sreg      <= hold;
            hold_full <= 1'b0;
            cnt       <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt + CW'(1);
          end else begin
            done <= 1'b1;
            cnt  <= '0;
            if (hold_full) begin
              sreg      <= hold;
              hold_full <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    load_ready = !hold_full;
    frame      = (state == SHIFT);
    Sout       = frame ? sreg[WIDTH-1] : 1'b0;
    sof        = frame && (cnt == '0);
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed and loopback bench for piso_serializer (WIDTH = 8).
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] Din = '0;
  logic         Sout, frame, sof, done;

  int errors = 0;
  int checks = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .Din(Din), .Sout(Sout), .frame(frame), .sof(sof), .done(done)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge (sample/drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if ({Sout, frame, sof, done, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state: got Sout/frame/sof/done/ready=%b, want 00001",
               {Sout, frame, sof, done, load_ready});
    end
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    w = 8'hA5;
    load_valid = 1'b1;
    Din = w;
    step();  // edge 0: accept
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready_after_accept: got %b want 0", load_ready);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (Sout !== w[8-i] || frame !== 1'b1 || sof !== (i == 1) || done !== 1'b0) begin
        errors++;
        $display("FAIL single_bit%0d: got Sout/frame/sof/done=%b%b%b%b want %b1%b0",
                 i, Sout, frame, sof, done, w[8-i], (i == 1));
      end
      if (i == 1) begin
        checks++;
        if (load_ready !== 1'b1) begin
          errors++; $display("FAIL single_ready_edge1: got %b want 1", load_ready);
        end
      end
    end
    step();  // edge 9
    checks++;
    if (frame !== 1'b0 || done !== 1'b1 || Sout !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got frame/done/Sout=%b%b%b want 010", frame, done, Sout);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL single_done_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int dcount;
    exp = 16'hF00F;
    dcount = 0;
    load_valid = 1'b1;
    Din = 8'hF0;
    step();  // edge 0: accept F0
    Din = 8'h0F;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 2) load_valid = 1'b0;  // 0F accepted at edge 2
      if (done) dcount++;
      checks++;
      if (Sout !== exp[16-i] || frame !== 1'b1 || sof !== (i == 1 || i == 9) ||
          done !== (i == 9)) begin
        errors++;
        $display("FAIL b2b_bit%0d: got Sout/frame/sof/done=%b%b%b%b want %b1%b%b",
                 i, Sout, frame, sof, done, exp[16-i], (i == 1 || i == 9), (i == 9));
      end
    end
    step();
    if (done) dcount++;
    checks++;
    if (frame !== 1'b0 || dcount != 2) begin
      errors++;
      $display("FAIL b2b_end: got frame=%b dones=%0d want frame=0 dones=2", frame, dcount);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [23:0] exp;
    exp = 24'h112233;
    load_valid = 1'b1;
    Din = 8'h11;
    step();  // edge 0: accept 11
    load_valid = 1'b0;
    step();  // edge 1: transfer 11, first bit out
    checks++;
    if (Sout !== exp[23]) begin
      errors++; $display("FAIL bp_bit1: got %b want %b", Sout, exp[23]);
    end
    load_valid = 1'b1;
    Din = 8'h22;
    step();  // edge 2: accept 22
    checks++;
    if (Sout !== exp[22]) begin
      errors++; $display("FAIL bp_bit2: got %b want %b", Sout, exp[22]);
    end
    Din = 8'h33;
    for (int i = 3; i <= 24; i++) begin
      step();
      if (i >= 3 && i <= 8) begin
        checks++;
        if (load_ready !== 1'b0) begin
          errors++; $display("FAIL bp_ready_edge%0d: got %b want 0", i, load_ready);
        end
      end
      if (i == 10) load_valid = 1'b0;  // 33 accepted at edge 10
      checks++;
      if (Sout !== exp[24-i] || frame !== 1'b1) begin
        errors++;
        $display("FAIL bp_bit%0d: got Sout/frame=%b%b want %b1", i, Sout, frame, exp[24-i]);
      end
    end
    step();
    checks++;
    if (frame !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL bp_end: got frame/done=%b%b want 01", frame, done);
    end
    step();
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] w;
    int dcount;
    dcount = 0;
    load_valid = 1'b1;
    Din = 8'hFF;
    step();
    load_valid = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({Sout, frame, sof, done, load_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL midreset_async: got Sout/frame/sof/done/ready=%b want 00001",
               {Sout, frame, sof, done, load_ready});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) dcount++;
    end
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || frame) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      errors++; $display("FAIL midreset_quiet: got %0d done/frame cycles want 0", dcount);
    end
    w = 8'h81;
    load_valid = 1'b1;
    Din = w;
    step();
    load_valid = 1'b0;
    dcount = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (done) dcount++;
      if (i <= 8) begin
        checks++;
        if (Sout !== w[8-i] || frame !== 1'b1) begin
          errors++;
          $display("FAIL midreset_bit%0d: got Sout/frame=%b%b want %b1", i, Sout, frame, w[8-i]);
        end
      end
    end
    checks++;
    if (dcount != 1) begin
      errors++; $display("FAIL midreset_done_count: got %0d want 1", dcount);
    end
  endtask

  task automatic test_random_loopback();
    logic [W-1:0] sent[$];
    logic [W-1:0] sipo;
    logic [W-1:0] expw;
    int nsent, nrecv, ndone, bitcnt, cycles;
    logic fire;
    nsent = 0; nrecv = 0; ndone = 0; bitcnt = 0; cycles = 0;
    sipo = '0;
    load_valid = 1'b0;
    while (nrecv < 200 && cycles < 20000) begin
      fire = load_valid && load_ready;
      step();
      cycles++;
      if (fire) begin
        sent.push_back(Din);
        nsent++;
      end
      if (done) ndone++;
      if (frame) begin
        if (sof) bitcnt = 0;
        sipo = {sipo[W-2:0], Sout};
        bitcnt++;
        if (bitcnt == W) begin
          bitcnt = 0;
          nrecv++;
          checks++;
          if (sent.size() == 0) begin
            errors++; $display("FAIL loop_word%0d: received %h with nothing sent", nrecv, sipo);
          end else begin
            expw = sent.pop_front();
            if (sipo !== expw) begin
              errors++; $display("FAIL loop_word%0d: got %h want %h", nrecv, sipo, expw);
            end
          end
        end
      end
      if (!(load_valid && !fire)) begin
        if (nsent < 200 && $urandom_range(0, 3) != 0) begin
          load_valid = 1'b1;
          Din = W'($urandom);
        end else begin
          load_valid = 1'b0;
        end
      end
    end
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) ndone++;
    end
    checks++;
    if (nrecv != 200 || ndone != 200) begin
      errors++;
      $display("FAIL loop_counts: got words=%0d dones=%0d want 200/200", nrecv, ndone);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
